// File: rtl/alu_op_sequencer_if.sv
// Command and response channels of alu_op_sequencer, each a valid/ready handshake.
// master = command producer / response consumer, slave = the sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPW-1:0]   cmd_op;
    logic [1:0]       cmd_sa;
    logic [1:0]       cmd_sb;
    logic [1:0]       cmd_dst;
    logic             cmd_sweep;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic [OPW-1:0]   rsp_op;

    modport master (
        output cmd_valid, cmd_op, cmd_sa, cmd_sb, cmd_dst, cmd_sweep, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sa, cmd_sb, cmd_dst, cmd_sweep, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_op
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues register-file operands to an external combinational ALU and returns captured results.
// Latency: rsp_valid rises SETTLE cycles after command accept (and after each sweep transfer).
// Backpressure: one command in flight; cmd_ready low until the last response transfers.
module alu_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int OPW    = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_sequencer_if.slave bus,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [1:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0]     RELOAD = 4'(SETTLE - 1);
    localparam logic [OPW-1:0] OP_MAX = {OPW{1'b1}};

    state_t           state;
    logic [WIDTH-1:0] rf [4];
    logic [3:0]       cnt;
    logic             sweep_q;
    logic [1:0]       dst_q;

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign busy          = (state != IDLE);
    assign rd_data       = rf[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            cnt            <= '0;
            sweep_q        <= 1'b0;
            dst_q          <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_cout   <= 1'b0;
            bus.rsp_op     <= '0;
        end else begin
            if (ld_en) rf[ld_addr] <= ld_data;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // Operand snapshot reads rf before any same-edge ld_en write lands.
                        alu_a   <= rf[bus.cmd_sa];
                        alu_b   <= rf[bus.cmd_sb];
                        alu_op  <= bus.cmd_sweep ? '0 : bus.cmd_op;
                        sweep_q <= bus.cmd_sweep;
                        dst_q   <= bus.cmd_dst;
                        cnt     <= RELOAD;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == 4'd0) begin
                        bus.rsp_result <= alu_result;
                        bus.rsp_cout   <= alu_cout;
                        bus.rsp_op     <= alu_op;
                        bus.rsp_valid  <= 1'b1;
                        // Placed after the ld_en write so the capture wins a same-register collision.
                        if (!sweep_q) rf[dst_q] <= alu_result;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        if (sweep_q && alu_op != OP_MAX) begin
                            alu_op <= alu_op + 1'b1;
                            cnt    <= RELOAD;
                            state  <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of alu_op_sequencer against a transaction-level model.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: SETTLE = 1
    alu_op_sequencer_if #(.WIDTH(4), .OPW(3)) bus_a ();
    logic       ld_en_a;
    logic [1:0] ld_addr_a, rd_addr_a;
    logic [3:0] ld_data_a, rd_data_a, alu_a_a, alu_b_a, alu_res_a;
    logic [2:0] alu_op_a;
    logic       alu_cout_a, busy_a;

    assign alu_res_a  = alu_a_a ^ alu_b_a ^ {1'b0, alu_op_a};
    assign alu_cout_a = alu_op_a[0];

    alu_op_sequencer #(.WIDTH(4), .OPW(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .ld_en(ld_en_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .alu_a(alu_a_a), .alu_b(alu_b_a), .alu_op(alu_op_a),
        .alu_result(alu_res_a), .alu_cout(alu_cout_a), .busy(busy_a)
    );

    // DUT B: SETTLE = 3
    alu_op_sequencer_if #(.WIDTH(4), .OPW(3)) bus_b ();
    logic       ld_en_b;
    logic [1:0] ld_addr_b, rd_addr_b;
    logic [3:0] ld_data_b, rd_data_b, alu_a_b, alu_b_b, alu_res_b;
    logic [2:0] alu_op_b;
    logic       alu_cout_b, busy_b;

    assign alu_res_b  = alu_a_b ^ alu_b_b ^ {1'b0, alu_op_b};
    assign alu_cout_b = alu_op_b[0];

    alu_op_sequencer #(.WIDTH(4), .OPW(3), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .ld_en(ld_en_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_op(alu_op_b),
        .alu_result(alu_res_b), .alu_cout(alu_cout_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;
    logic [3:0] mrf [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [1:0] addr, input logic [3:0] data);
        ld_en_a = 1'b1; ld_addr_a = addr; ld_data_a = data;
        tick();
        ld_en_a = 1'b0;
        mrf[addr] = data;
    endtask

    task automatic chk_rf_a(input string tag);
        for (int r = 0; r < 4; r++) begin
            rd_addr_a = 2'(r);
            #1;
            chk(tag, rd_data_a, mrf[r]);
        end
    endtask

    // One command on DUT A; expected responses come from the model register file.
    task automatic do_cmd(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] dst, input logic sweep, input int rdy_pct);
        logic [3:0] ea, eb, er;
        logic [2:0] eop;
        int w, lat, n;
        bit got;
        ea = mrf[sa]; eb = mrf[sb]; er = '0;
        w = 0;
        while (!bus_a.cmd_ready && w < 20) begin tick(); w++; end
        chk("cmd_ready_idle", bus_a.cmd_ready, 1);
        bus_a.cmd_op = op; bus_a.cmd_sa = sa; bus_a.cmd_sb = sb;
        bus_a.cmd_dst = dst; bus_a.cmd_sweep = sweep; bus_a.cmd_valid = 1'b1;
        tick();
        bus_a.cmd_valid = 1'b0;
        chk("alu_a", alu_a_a, ea);
        chk("alu_b", alu_b_a, eb);
        chk("alu_op", alu_op_a, sweep ? 3'd0 : op);
        chk("busy_after_accept", busy_a, 1);
        chk("cmd_ready_busy", bus_a.cmd_ready, 0);
        n = sweep ? 8 : 1;
        for (int k = 0; k < n; k++) begin
            eop = sweep ? 3'(k) : op;
            er  = ea ^ eb ^ {1'b0, eop};
            lat = 0;
            while (!bus_a.rsp_valid && lat < 50) begin tick(); lat++; end
            chk("rsp_latency", lat, 1);
            got = 0; w = 0;
            while (!got && w < 50) begin
                chk("rsp_valid_hold", bus_a.rsp_valid, 1);
                chk("rsp_result", bus_a.rsp_result, er);
                chk("rsp_cout", bus_a.rsp_cout, eop[0]);
                chk("rsp_op", bus_a.rsp_op, eop);
                chk("cmd_ready_resp", bus_a.cmd_ready, 0);
                bus_a.rsp_ready = ($urandom_range(99) < rdy_pct);
                got = bus_a.rsp_ready;
                tick();
                bus_a.rsp_ready = 1'b0;
                w++;
            end
        end
        chk("rsp_valid_done", bus_a.rsp_valid, 0);
        chk("busy_done", busy_a, 0);
        chk("cmd_ready_done", bus_a.cmd_ready, 1);
        if (!sweep) mrf[dst] = er;
        chk_rf_a("regfile");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat;
        bit found;
        rst = 1'b1;
        ld_en_a = 0; ld_addr_a = 0; ld_data_a = 0; rd_addr_a = 0;
        ld_en_b = 0; ld_addr_b = 0; ld_data_b = 0; rd_addr_b = 0;
        bus_a.cmd_valid = 0; bus_a.cmd_op = 0; bus_a.cmd_sa = 0; bus_a.cmd_sb = 0;
        bus_a.cmd_dst = 0; bus_a.cmd_sweep = 0; bus_a.rsp_ready = 0;
        bus_b.cmd_valid = 0; bus_b.cmd_op = 0; bus_b.cmd_sa = 0; bus_b.cmd_sb = 0;
        bus_b.cmd_dst = 0; bus_b.cmd_sweep = 0; bus_b.rsp_ready = 0;
        for (int r = 0; r < 4; r++) mrf[r] = '0;

        // Reset state
        tick(); tick();
        chk("cmd_ready_in_rst", bus_a.cmd_ready, 0);
        rst = 1'b0;
        tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_rsp_valid", bus_a.rsp_valid, 0);
        chk("rst_alu_a", alu_a_a, 0);
        chk("rst_alu_op", alu_op_a, 0);
        chk("rst_rsp_result", bus_a.rsp_result, 0);
        chk("rst_cmd_ready", bus_a.cmd_ready, 1);
        chk_rf_a("rst_regfile");

        // Single op then sweep on the same operands
        load_a(2'd0, 4'b1011);
        load_a(2'd1, 4'b1000);
        do_cmd(3'd5, 2'd0, 2'd1, 2'd2, 1'b0, 100);
        do_cmd(3'd0, 2'd0, 2'd1, 2'd3, 1'b1, 100);
        do_cmd(3'd3, 2'd1, 2'd1, 2'd3, 1'b0, 40);

        // Collisions: load on accept edge, then load to dst on capture edge
        mrf[3] = 4'b1000 ^ 4'b1000 ^ 4'd3;
        bus_a.cmd_op = 3'd0; bus_a.cmd_sa = 2'd0; bus_a.cmd_sb = 2'd1;
        bus_a.cmd_dst = 2'd2; bus_a.cmd_sweep = 1'b0; bus_a.cmd_valid = 1'b1;
        ld_en_a = 1'b1; ld_addr_a = 2'd1; ld_data_a = 4'b1111;
        tick();
        bus_a.cmd_valid = 1'b0;
        ld_addr_a = 2'd2; ld_data_a = 4'b1111;
        chk("coll_alu_b_old", alu_b_a, 4'b1000);
        tick();
        ld_en_a = 1'b0;
        chk("coll_rsp_valid", bus_a.rsp_valid, 1);
        chk("coll_rsp_result", bus_a.rsp_result, 4'b0011);
        mrf[1] = 4'b1111; mrf[2] = 4'b0011;
        bus_a.rsp_ready = 1'b1;
        tick();
        bus_a.rsp_ready = 1'b0;
        chk_rf_a("coll_regfile");

        // Reset during op-3 issue of a sweep
        bus_a.cmd_sa = 2'd0; bus_a.cmd_sb = 2'd1; bus_a.cmd_sweep = 1'b1; bus_a.cmd_valid = 1'b1;
        tick();
        bus_a.cmd_valid = 1'b0;
        bus_a.rsp_ready = 1'b1;
        found = 0; w = 0;
        while (!found && w < 60) begin
            if (alu_op_a == 3'd3 && busy_a && !bus_a.rsp_valid) found = 1;
            else begin tick(); w++; end
        end
        chk("sweep_reached_op3", found, 1);
        rst = 1'b1;
        #1;
        chk("cmd_ready_rst_mid", bus_a.cmd_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_rsp_valid", bus_a.rsp_valid, 0);
        chk("abort_cmd_ready", bus_a.cmd_ready, 1);
        chk("abort_alu_op", alu_op_a, 0);
        for (int r = 0; r < 4; r++) mrf[r] = '0;
        chk_rf_a("abort_regfile");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_rsp", bus_a.rsp_valid, 0);
        end
        bus_a.rsp_ready = 1'b0;

        // Chained dependency through R0
        load_a(2'd1, 4'h5);
        load_a(2'd2, 4'h3);
        do_cmd(3'd2, 2'd1, 2'd2, 2'd0, 1'b0, 100);
        do_cmd(3'd7, 2'd0, 2'd0, 2'd3, 1'b0, 100);

        // Randomized commands and loads
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 1) load_a(2'($urandom_range(3)), 4'($urandom_range(15)));
            do_cmd(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                   2'($urandom_range(3)), ($urandom_range(7) == 0), 60);
        end

        // Backpressure on the SETTLE=3 instance
        ld_en_b = 1'b1; ld_addr_b = 2'd0; ld_data_b = 4'b1011;
        tick();
        ld_addr_b = 2'd1; ld_data_b = 4'b1000;
        tick();
        ld_en_b = 1'b0;
        bus_b.cmd_op = 3'd5; bus_b.cmd_sa = 2'd0; bus_b.cmd_sb = 2'd1;
        bus_b.cmd_dst = 2'd2; bus_b.cmd_sweep = 1'b0; bus_b.cmd_valid = 1'b1;
        tick();
        bus_b.cmd_valid = 1'b0;
        lat = 0;
        while (!bus_b.rsp_valid && lat < 50) begin
            chk("b_cmd_ready_issue", bus_b.cmd_ready, 0);
            tick(); lat++;
        end
        chk("b_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk("b_rsp_valid_hold", bus_b.rsp_valid, 1);
            chk("b_rsp_result", bus_b.rsp_result, 4'b0110);
            chk("b_rsp_cout", bus_b.rsp_cout, 1);
            chk("b_rsp_op", bus_b.rsp_op, 3'd5);
            chk("b_cmd_ready_resp", bus_b.cmd_ready, 0);
            tick();
        end
        bus_b.rsp_ready = 1'b1;
        tick();
        bus_b.rsp_ready = 1'b0;
        chk("b_rsp_valid_done", bus_b.rsp_valid, 0);
        chk("b_cmd_ready_done", bus_b.cmd_ready, 1);
        chk("b_busy_done", busy_b, 0);
        rd_addr_b = 2'd2;
        #1;
        chk("b_r2", rd_data_b, 4'b0110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue-and-capture controller for the team's 4-bit combinational ALU (ports A, B, operation[2:0], result, cout).
- Owns a small operand register file and accepts commands over a valid/ready handshake.
- For each command it drives the ALU inputs, waits a programmable settle time, captures result/cout and returns them over a valid/ready response channel.
- Sweep mode steps one operand pair through all 8 ALU operations as 8 back-to-back responses.

Parameters:
- WIDTH, 4, ALU data width.
- OPW, 3, ALU operation code width.
- SETTLE, 1, clock cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  OPW  ALU operation.
- cmd_sa  in  2  register index for operand A.
- cmd_sb  in  2  register index for operand B.
- cmd_dst  in  2  destination register for the result.
- cmd_sweep  in  1  1 = run ops 0..7 on the operand pair; cmd_op and cmd_dst are ignored.
- ld_en  in  1  register-file load strobe.
- ld_addr  in  2  load index.
- ld_data  in  WIDTH  load data.
- rd_addr  in  2  debug read index.
- rd_data  out  WIDTH  combinational read of regfile[rd_addr].
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_op  out  OPW  to ALU operation.
- alu_result  in  WIDTH  from ALU result.
- alu_cout  in  1  from ALU cout.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured result.
- rsp_cout  out  1  captured carry.
- rsp_op  out  OPW  operation that produced the response.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - State goes to IDLE; the register file (4 x WIDTH) clears to 0.
  - Outputs go to 0: alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_cout, rsp_op, busy.
  - cmd_ready is 0 while rst is high.
  - Reset mid-command or mid-sweep aborts immediately: no response is issued and no register write occurs.
- State machine: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, snapshot regfile[cmd_sa] into alu_a and regfile[cmd_sb] into alu_b.
  - Set alu_op = cmd_sweep ? 0 : cmd_op. Latch sweep flag and dst. Load the settle counter with SETTLE-1. Go to ISSUE.
- ISSUE:
  - alu_* held stable.
  - Counter decrements each cycle.
  - At the edge where the counter equals 0:
    - Capture alu_result, alu_cout and alu_op into the rsp_* registers and set rsp_valid.
    - If not sweep, also write alu_result to regfile[dst].
    - Go to RESP.
- Latency: rsp_valid rises exactly SETTLE cycles after the accept edge (SETTLE=1: the cycle after accept).
- RESP:
  - rsp_valid and rsp_* are held until rsp_ready.
  - On rsp_valid & rsp_ready:
    - Sweep and alu_op != 7: alu_op += 1, operands unchanged, reload counter, go to ISSUE.
    - Otherwise: go to IDLE and clear rsp_valid.
  - alu_* keep their last values in IDLE.
- Handshake:
  - cmd_ready is 0 in ISSUE and RESP; commands are never queued.
  - Once rsp_valid is 1 it drops only after a transfer; rsp_* do not change while rsp_valid=1 and rsp_ready=0.
- Register-file write ports, simultaneous events:
  - ld_en writes in any state.
  - If the capture write and ld_en target the same register at the same edge, the capture write wins. Different registers: both write.
  - ld_en to cmd_sa/cmd_sb on the accept edge: the operand snapshot uses the pre-write (old) value.
  - cmd_sa == cmd_sb is legal; both operands get the same value.
  - A result written to dst is visible to the next command's operand read (no stale path).
- Arithmetic: the block performs no arithmetic on data. The 3-bit op increment in sweep stops at 7, with no wrap.
- rd_data is combinational and reflects a write from the cycle after its edge.

Test Plan:
Bench ALU stub: result = a ^ b ^ {1'b0,op}, cout = op[0].
1. Reset then single op: load R0=4'b1011, R1=4'b1000; cmd op=5, sa=0, sb=1, dst=2, rsp_ready=1 -> rsp_valid exactly 1 cycle after accept, rsp_result=4'b0110, rsp_cout=1, rsp_op=5, R2=4'b0110, cmd_ready back to 1 the cycle after the transfer.
2. Sweep: same operands, cmd_sweep=1 -> 8 responses with rsp_op 0..7 and results 0011,0010,0001,0000,0111,0110,0101,0100; cout alternates 0,1; regfile unchanged; busy=0 after the 8th transfer.
3. Backpressure with SETTLE=3: hold rsp_ready=0 for 5 cycles -> rsp_valid rises 3 cycles after accept and holds; rsp_* stable; cmd_ready=0 throughout; response delivered on the first rsp_ready=1.
4. Collisions: ld_en to R1 (data 4'b1111) on the accept edge -> alu_b=4'b1000 (old value). ld_en to dst=2 (data 4'b1111) on the capture edge -> R2 holds the captured result.
5. Reset in sweep: assert rst during the op-3 ISSUE state -> the next cycle has busy=0, rsp_valid=0, all registers 0 and cmd_ready=1 after rst deasserts; no further responses.
6. Chained dependency: cmd dst=0 then cmd sa=0 -> the second command's alu_a equals the first command's result.
